// File: rtl/tiler_scheduler.sv
// Front-end sequencer for the tiler: buffers triangles, drops zero-area ones, forces CCW winding.
// Latency: triangle accepted on edge t gives load in cycle t+3; fin_calcul on edge f gives next load in f+3.
// Backpressure: tri_ready (registered) is low while the triangle FIFO is full; the tiler is paced by fin_calcul.
//
// Ports: clk, reset (async active-low); tri_valid/tri_ready/tri_a/tri_b/tri_c upstream triangle push;
// frame_end closes the frame; load/A/B/C/fin_calcul/pixel_out tiler handshake; busy, frame_done,
// tri_count, skip_count, pix_count per-frame statistics; timeout_err sticky watchdog flag.
module tiler_scheduler #(
    parameter int N       = 9,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tri_valid,
    output logic                 tri_ready,
    input  logic [3:0][N-1:0]    tri_a,
    input  logic [3:0][N-1:0]    tri_b,
    input  logic [3:0][N-1:0]    tri_c,
    input  logic                 frame_end,
    output logic                 load,
    output logic [3:0][N-1:0]    A,
    output logic [3:0][N-1:0]    B,
    output logic [3:0][N-1:0]    C,
    input  logic                 fin_calcul,
    input  logic                 pixel_out,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          tri_count,
    output logic [15:0]          skip_count,
    output logic [2*N+3:0]       pix_count,
    output logic                 timeout_err
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int PW = 2 * N + 4;

    // Working triangle: [0]=A, [1]=B, [2]=C; each vertex [0]=x, [1]=y, [2]=depth, [3]=luminance.
    typedef logic [2:0][3:0][N-1:0] tri_t;
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOAD, S_ARM, S_WAIT} state_t;

    state_t          state, state_n;
    tri_t            work, fifo_dat, fifo_wdat;
    logic            push, pop, fifo_empty, fifo_ne_nxt;
    logic            end_pending;
    logic [WW-1:0]   wdog;
    logic            fd_set, skip_inc, tri_inc, pix_inc, to_set, swap, wd_clr;
    logic [15:0]     tri_cnt_n, skip_cnt_n;
    logic [PW-1:0]   pix_cnt_n;

    logic signed [N:0]     d_bx, d_cy, d_cx, d_by;
    logic signed [2*N+1:0] p1, p2;
    logic signed [2*N+2:0] area;

    assign push      = tri_valid && tri_ready;
    assign fifo_wdat = {tri_c, tri_b, tri_a};

    sched_fifo #(.W($bits(tri_t)), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .wdat   (fifo_wdat),
        .rdat   (fifo_dat),
        .rdy    (tri_ready),
        .empty  (fifo_empty),
        .ne_nxt (fifo_ne_nxt)
    );

    // The working register is itself a flop, so the tiler vertex outputs are registered.
    assign A = work[0];
    assign B = work[1];
    assign C = work[2];

    // Full-precision signed area: N+1 bit differences, 2N+2 bit products, 2N+3 bit result.
    always_comb begin
        d_bx = $signed({1'b0, work[1][0]}) - $signed({1'b0, work[0][0]});
        d_cy = $signed({1'b0, work[2][1]}) - $signed({1'b0, work[0][1]});
        d_cx = $signed({1'b0, work[2][0]}) - $signed({1'b0, work[0][0]});
        d_by = $signed({1'b0, work[1][1]}) - $signed({1'b0, work[0][1]});
        p1   = $signed({{(N+1){d_bx[N]}}, d_bx}) * $signed({{(N+1){d_cy[N]}}, d_cy});
        p2   = $signed({{(N+1){d_cx[N]}}, d_cx}) * $signed({{(N+1){d_by[N]}}, d_by});
        area = $signed({p1[2*N+1], p1}) - $signed({p2[2*N+1], p2});
    end

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        fd_set   = 1'b0;
        skip_inc = 1'b0;
        tri_inc  = 1'b0;
        pix_inc  = 1'b0;
        to_set   = 1'b0;
        swap     = 1'b0;
        wd_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = S_CHECK;
                end else if (end_pending) begin
                    fd_set  = 1'b1;
                end
            end
            S_CHECK: begin
                if (area == '0) begin
                    skip_inc = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    swap    = area[2*N+2];
                    state_n = S_LOAD;
                end
            end
            S_LOAD:  state_n = S_ARM;
            // fin_calcul may still show the previous triangle's done here, so it is not looked at.
            S_ARM: begin
                wd_clr  = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                pix_inc = pixel_out && !fin_calcul;
                if (fin_calcul) begin
                    tri_inc = 1'b1;
                    state_n = S_IDLE;
                end else if (wdog == WW'(TIMEOUT - 1)) begin
                    to_set  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Counters clear on the edge that ends the frame_done cycle; events on that edge land in the new frame.
    always_comb begin
        tri_cnt_n  = frame_done ? '0 : tri_count;
        skip_cnt_n = frame_done ? '0 : skip_count;
        pix_cnt_n  = frame_done ? '0 : pix_count;
        if (tri_inc && tri_cnt_n != '1)   tri_cnt_n  = tri_cnt_n + 16'd1;
        if (skip_inc && skip_cnt_n != '1) skip_cnt_n = skip_cnt_n + 16'd1;
        if (pix_inc && pix_cnt_n != '1)   pix_cnt_n  = pix_cnt_n + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            work        <= '0;
            wdog        <= '0;
            end_pending <= 1'b0;
            load        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            tri_count   <= '0;
            skip_count  <= '0;
            pix_count   <= '0;
        end else begin
            state       <= state_n;
            load        <= (state_n == S_LOAD);
            busy        <= (state_n != S_IDLE) || fifo_ne_nxt;
            frame_done  <= fd_set;
            end_pending <= frame_end || (end_pending && !fd_set);
            timeout_err <= timeout_err || to_set;
            tri_count   <= tri_cnt_n;
            skip_count  <= skip_cnt_n;
            pix_count   <= pix_cnt_n;
            if (pop) begin
                work <= fifo_dat;
            end else if (swap) begin
                work[1] <= work[2];
                work[2] <= work[1];
            end
            if (wd_clr) begin
                wdog <= '0;
            end else if (state == S_WAIT && wdog != '1) begin
                wdog <= wdog + WW'(1);
            end
        end
    end
endmodule

// Generic synchronous FIFO with a registered ready (not full) output.
// Latency: data written on a push edge is readable (rdat) in the following cycle.
// Backpressure: rdy is low while full; a pop in the same cycle does not reopen a full FIFO.
module sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdat,
    output logic [W-1:0] rdat,
    output logic         rdy,
    output logic         empty,
    output logic         ne_nxt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, cnt_n;

    assign cnt_n  = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign empty  = (cnt == '0);
    assign ne_nxt = (cnt_n != '0);
    assign rdat   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rdy    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt_n;
            rdy <= (cnt_n != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdat;
    end
endmodule

// File: tb/tb_tiler_scheduler.sv
module tb_tiler_scheduler;
    localparam int N       = 9;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 50;

    typedef logic [3:0][N-1:0] vtx_t;
    typedef struct {
        vtx_t a;
        vtx_t b;
        vtx_t c;
        logic exp_load;
        vtx_t exp_b;
        vtx_t exp_c;
        int   pix;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tri_valid = 1'b0;
    logic frame_end = 1'b0;
    logic fin_calcul = 1'b0;
    logic pixel_out = 1'b0;
    vtx_t tri_a = '0, tri_b = '0, tri_c = '0;
    logic tri_ready, load, busy, frame_done, timeout_err;
    vtx_t A, B, C;
    logic [15:0] tri_count, skip_count;
    logic [2*N+3:0] pix_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    tiler_scheduler #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_a(tri_a), .tri_b(tri_b), .tri_c(tri_c), .frame_end(frame_end),
        .load(load), .A(A), .B(B), .C(C), .fin_calcul(fin_calcul), .pixel_out(pixel_out),
        .busy(busy), .frame_done(frame_done), .tri_count(tri_count), .skip_count(skip_count),
        .pix_count(pix_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL tb_watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vtx_t mkv(input int x, input int y, input int d, input int l);
        return {N'(l), N'(d), N'(y), N'(x)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a triangle and returns the cycle index of the accepting edge.
    task automatic push_tri(input vtx_t a, input vtx_t b, input vtx_t c, output int acc);
        tri_a = a;
        tri_b = b;
        tri_c = c;
        tri_valid = 1'b1;
        for (int w = 0; w < 200 && !tri_ready; w++) step();
        chk("push_ready", 64'(tri_ready), 64'(1));
        @(posedge clk);
        #1;
        acc = cyc;
        tri_valid = 1'b0;
    endtask

    // Called at the negedge of the load cycle: ARM shows a stale done, then the tiler works.
    task automatic tiler_run(input int cycles, input int pix);
        step();
        fin_calcul = 1'b1;
        pixel_out  = 1'b0;
        step();
        fin_calcul = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            pixel_out = (i < pix);
            step();
        end
        fin_calcul = 1'b1;
        pixel_out  = 1'b1;
        step();
        fin_calcul = 1'b0;
        pixel_out  = 1'b0;
    endtask

    task automatic wait_load(output int lc);
        int found;
        found = 0;
        lc = 0;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (load) begin
                found = 1;
                lc = cyc;
                break;
            end
        end
        chk("load_seen", 64'(found), 64'(1));
    endtask

    vec_t vecs[6];
    int acc, lc, fcyc, acc0, exp_tri, exp_skip, exp_pix, seen;

    initial begin
        vecs[0] = '{mkv(10,10,5,100), mkv(20,10,5,100), mkv(10,20,5,100), 1'b1,
                    mkv(20,10,5,100), mkv(10,20,5,100), 7};
        vecs[1] = '{mkv(10,10,5,100), mkv(10,20,5,100), mkv(20,10,5,100), 1'b1,
                    mkv(20,10,5,100), mkv(10,20,5,100), 3};
        vecs[2] = '{mkv(0,0,1,1), mkv(5,5,1,1), mkv(10,10,1,1), 1'b0, '0, '0, 0};
        vecs[3] = '{mkv(511,0,7,200), mkv(0,511,7,200), mkv(511,511,7,200), 1'b1,
                    mkv(511,511,7,200), mkv(0,511,7,200), 5};
        vecs[4] = '{mkv(0,0,2,2), mkv(511,511,2,2), mkv(0,0,2,2), 1'b0, '0, '0, 0};
        vecs[5] = '{mkv(0,0,0,511), mkv(1,0,0,511), mkv(0,1,0,511), 1'b1,
                    mkv(1,0,0,511), mkv(0,1,0,511), 0};
        exp_tri = 0; exp_skip = 0; exp_pix = 0;

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tri_ready", 64'(tri_ready), 64'(0));
        chk("rst_load", 64'(load), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_timeout_err", 64'(timeout_err), 64'(0));
        chk("rst_A", 64'(A), 64'(0));
        chk("rst_tri_count", 64'(tri_count), 64'(0));
        chk("rst_pix_count", 64'(pix_count), 64'(0));
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("ready_after_rst", 64'(tri_ready), 64'(1));
        repeat (4) step();
        @(negedge clk);
        chk("idle_load", 64'(load), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_skip", 64'(skip_count), 64'(0));
        step();

        // Table-driven triangles: timing of load, winding fix-up, degenerate drop, counters
        for (int i = 0; i < 6; i++) begin
            push_tri(vecs[i].a, vecs[i].b, vecs[i].c, acc);
            @(negedge clk);
            chk("load_t1", 64'(load), 64'(0));
            step();
            @(negedge clk);
            chk("load_t2", 64'(load), 64'(0));
            step();
            @(negedge clk);
            chk("load_t3", 64'(load), 64'(vecs[i].exp_load));
            if (vecs[i].exp_load) begin
                chk("vec_A", 64'(A), 64'(vecs[i].a));
                chk("vec_B", 64'(B), 64'(vecs[i].exp_b));
                chk("vec_C", 64'(C), 64'(vecs[i].exp_c));
                exp_tri++;
                exp_pix += vecs[i].pix;
                tiler_run(20, vecs[i].pix);
                @(negedge clk);
                chk("vec_tri_count", 64'(tri_count), 64'(exp_tri));
                chk("vec_pix_count", 64'(pix_count), 64'(exp_pix));
            end else begin
                exp_skip++;
                chk("vec_skip_count", 64'(skip_count), 64'(exp_skip));
                chk("vec_busy_after_skip", 64'(busy), 64'(0));
            end
            step();
        end

        // Frame end: pulse one cycle after end_pending, totals visible, then cleared
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        @(negedge clk);
        chk("fd_early", 64'(frame_done), 64'(0));
        step();
        @(negedge clk);
        chk("fd_pulse", 64'(frame_done), 64'(1));
        chk("fd_tri_count", 64'(tri_count), 64'(4));
        chk("fd_skip_count", 64'(skip_count), 64'(2));
        chk("fd_pix_count", 64'(pix_count), 64'(15));
        step();
        @(negedge clk);
        chk("fd_after", 64'(frame_done), 64'(0));
        chk("clr_tri_count", 64'(tri_count), 64'(0));
        chk("clr_skip_count", 64'(skip_count), 64'(0));
        chk("clr_pix_count", 64'(pix_count), 64'(0));
        step();

        // Back-to-back: 6 triangles against a slow tiler, FIFO fills after the 5th accept
        acc0 = 0;
        fcyc = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    tri_a = mkv(k*10, 0, 1, k);
                    tri_b = mkv(k*10+8, 0, 1, k);
                    tri_c = mkv(k*10, 8, 1, k);
                    tri_valid = 1'b1;
                    for (int w = 0; w < 400 && !tri_ready; w++) step();
                    chk("b2b_ready", 64'(tri_ready), 64'(1));
                    @(posedge clk);
                    #1;
                    if (k == 0) acc0 = cyc;
                    if (k == 4) begin
                        @(negedge clk);
                        chk("b2b_ready_full", 64'(tri_ready), 64'(0));
                    end
                end
                tri_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    wait_load(lc);
                    chk("b2b_order", 64'(A[0]), 64'(j*10));
                    if (j == 0) chk("b2b_first_lat", 64'(lc - acc0), 64'(2));
                    else        chk("b2b_gap", 64'(lc - fcyc), 64'(2));
                    step();
                    fin_calcul = 1'b1;
                    step();
                    fin_calcul = 1'b0;
                    repeat (10) step();
                    fin_calcul = 1'b1;
                    step();
                    fcyc = cyc;
                    fin_calcul = 1'b0;
                end
            end
        join
        @(negedge clk);
        chk("b2b_tri_count", 64'(tri_count), 64'(6));
        chk("b2b_busy", 64'(busy), 64'(0));
        step();

        // Watchdog: fin_calcul never rises
        push_tri(vecs[0].a, vecs[0].b, vecs[0].c, acc);
        wait_load(lc);
        repeat (51) step();
        @(negedge clk);
        chk("to_early", 64'(timeout_err), 64'(0));
        step();
        @(negedge clk);
        chk("to_set", 64'(timeout_err), 64'(1));
        chk("to_tri_unchanged", 64'(tri_count), 64'(6));
        chk("to_busy", 64'(busy), 64'(0));
        step();

        // Reset mid-WAIT with pixels counted and a frame_end pending
        push_tri(vecs[0].a, vecs[0].b, vecs[0].c, acc);
        wait_load(lc);
        step();
        step();
        pixel_out = 1'b1;
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        step();
        pixel_out = 1'b0;
        @(negedge clk);
        chk("mid_pix_count", 64'(pix_count), 64'(3));
        chk("mid_sticky_to", 64'(timeout_err), 64'(1));
        #1;
        reset = 1'b0;
        #1;
        chk("mrst_tri_ready", 64'(tri_ready), 64'(0));
        chk("mrst_load", 64'(load), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_frame_done", 64'(frame_done), 64'(0));
        chk("mrst_timeout_err", 64'(timeout_err), 64'(0));
        chk("mrst_A", 64'(A), 64'(0));
        chk("mrst_B", 64'(B), 64'(0));
        chk("mrst_C", 64'(C), 64'(0));
        chk("mrst_tri_count", 64'(tri_count), 64'(0));
        chk("mrst_skip_count", 64'(skip_count), 64'(0));
        chk("mrst_pix_count", 64'(pix_count), 64'(0));
        step();
        step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("mrst_ready_after", 64'(tri_ready), 64'(1));
        seen = 0;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            if (frame_done || load || busy) seen++;
        end
        chk("mrst_quiet", 64'(seen), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tiler_scheduler.md
# tiler_scheduler

Front-end sequencer for the tiler in the Z-buffer rasterizer. It buffers incoming triangles in a small FIFO and discards degenerate (zero-area) triangles. It normalises winding to counter-clockwise, drives the tiler's `load`/`fin_calcul` handshake one triangle at a time with a watchdog, and reports per-frame triangle and pixel statistics.

## Interface
- `N`, 9: coordinate/field width; each vertex is `[3:0][N-1:0]`, fields [0]=x, [1]=y, [2]=depth, [3]=luminance, all unsigned.
- `DEPTH`, 4: triangle FIFO entries (power of two, ≥2).
- `TIMEOUT`, 65535: maximum cycles in WAIT before abort.
- `clk` in 1: the single clock.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `tri_valid` in 1: upstream triangle valid.
- `tri_ready` out 1: FIFO not full.
- `tri_a`, `tri_b`, `tri_c` in 4×N each: vertices A, B, C.
- `frame_end` in 1: one-cycle pulse; no more triangles in the current frame.
- `load` out 1: one-cycle start pulse to the tiler.
- `A`, `B`, `C` out 4×N each: vertices to the tiler, stable from LOAD until leaving WAIT.
- `fin_calcul` in 1: tiler done (level).
- `pixel_out` in 1: tiler pixel strobe.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.
- `frame_done` out 1: one-cycle pulse.
- `tri_count` out 16: triangles completed this frame.
- `skip_count` out 16: degenerate triangles dropped this frame.
- `pix_count` out 2N+4: pixels emitted this frame.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- FIFO push on `tri_valid && tri_ready`. `tri_ready` is registered and equals `!full`. A push is refused when full even if a pop occurs in the same cycle. Push and pop may happen in the same cycle when the FIFO is not full.
- `frame_end` sets the `end_pending` flag. A triangle accepted in the same cycle as `frame_end` belongs to the ending frame.
- State machine:
  - IDLE:
    - If the FIFO is non-empty: pop into the working register, go to CHECK.
    - Else if `end_pending`: assert `frame_done`, clear `end_pending`, stay in IDLE.
  - CHECK: register `area = (bx-ax)*(cy-ay) - (cx-ax)*(by-ay)`.
    - Differences are signed N+1 bits, products 2N+2 bits, result 2N+3 bits, with no truncation.
    - If `area == 0`: `skip_count++`, go to IDLE.
    - If `area < 0`: swap B and C in the working register.
    - Otherwise go to LOAD.
  - LOAD: `load = 1` for this cycle only, with `A`/`B`/`C` driven from the working register. Go to ARM.
  - ARM: clear the watchdog; `fin_calcul` is ignored in this cycle because the tiler may still show the previous done. Go to WAIT.
  - WAIT:
    - Each cycle with `pixel_out && !fin_calcul`: `pix_count++`.
    - If `fin_calcul == 1`: `tri_count++`, go to IDLE.
    - Else if the watchdog reaches TIMEOUT−1: set `timeout_err`, do not count the triangle, go to IDLE.
- All counters saturate at their maximum value.
- During the `frame_done` cycle, the counters show the frame totals. On the same clock edge they clear, so they read 0 in the next cycle. A pixel or triangle event coinciding with that edge counts toward the new frame.
- `timeout_err` is cleared only by reset.
- Reset, including mid-operation: state IDLE, FIFO empty, `end_pending` cleared, all counters cleared. The in-flight triangle is abandoned and no `frame_done` is generated for it.

## Timing
- Reset values:
  - `tri_ready = 0`; it goes to 1 in the first cycle after reset deassertion.
  - `load`, `busy`, `frame_done`, `timeout_err` = 0.
  - `A`/`B`/`C` = 0.
  - All counters = 0.
- All outputs are registered.
- Empty FIFO, IDLE: a triangle accepted on edge t gives `load = 1` in cycle t+3 (pop at t+1, CHECK at t+2).
- Back-to-back triangles: `fin_calcul` sampled high on edge f gives the next `load` in cycle f+3.
- Degenerate triangle: occupies 2 cycles (IDLE, CHECK) and produces no `load`.
- `frame_done` is asserted 1 cycle after IDLE is reached with an empty FIFO and `end_pending` set.

## Test plan
- Reset, then idle 5 cycles → `tri_ready = 1`, `load = 0`, `busy = 0`, all counters 0.
- Push A=(10,10,5,100), B=(20,10,5,100), C=(10,20,5,100) (area +100). Tiler holds `fin_calcul` low for 20 cycles with 7 `pixel_out` strobes, then raises it. Then pulse `frame_end`. → `load` in cycle t+3 with B/C unswapped; `frame_done` shows `tri_count = 1`, `pix_count = 7`, `skip_count = 0`; counters read 0 the next cycle.
- Push the same triangle with B and C exchanged (area −100) → tiler receives B=(20,10), C=(10,20).
- Push collinear (0,0), (5,5), (10,10) → no `load`, `skip_count = 1`.
- Push 6 triangles back-to-back with DEPTH=4 while the tiler is slow → `tri_ready` drops after the 5th accept (1 in service + 4 buffered). All 6 are processed in order, with 3 cycles between `fin_calcul` and the next `load`.
- TIMEOUT=50, `fin_calcul` held low → `timeout_err` set 51 cycles after `load` (ARM plus 50 WAIT cycles), `tri_count` unchanged. Assert reset mid-WAIT on a second triangle → all outputs return to their reset values immediately.
